// File: rtl/timer_switch_pkg.sv
// Shared types for the multi-channel timed light switch.
// Holds the per-channel FSM states and the button mode encoding.
package timer_switch_pkg;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_e;

  // 2'b11 is not enumerated; channels treat it as RETRIG.
  typedef enum logic [1:0] {
    MODE_RETRIG  = 2'b00,
    MODE_ONESHOT = 2'b01,
    MODE_TOGGLE  = 2'b10
  } mode_e;

endpackage

// File: rtl/timer_switch_ch.sv
// One light channel: button edge detect, OFF/ON FSM, on-time down-counter, warn window.
// light follows the accepted rise at the same edge; no backpressure, every rise is acted on.
module timer_switch_ch
  import timer_switch_pkg::*;
#(
  parameter int ON_CYCLES   = 20,
  parameter int WARN_CYCLES = 3,
  parameter int CW          = $clog2(ON_CYCLES + 1)
) (
  input  logic       clock_1Hz,
  input  logic       reset_n,
  input  logic       btn,
  input  logic [1:0] mode,
  input  logic       all_off,
  output logic       light,
  output logic       warn
);

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES);
  localparam logic [CW-1:0] WARN_LIM = CW'(WARN_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state;
  logic [CW-1:0] cnt;
  logic          btn_prev;
  logic          armed;
  logic          rise;
  logic          is_toggle;
  logic          is_oneshot;
  logic          load;
  logic          tog_off;

  // armed stays low until the button has been seen released after reset,
  // so a button held through reset release never counts as a press.
  assign rise       = btn && !btn_prev && armed;
  assign is_toggle  = (mode == MODE_TOGGLE);
  assign is_oneshot = (mode == MODE_ONESHOT);
  assign load       = !all_off && rise && ((state == ST_OFF) || (!is_toggle && !is_oneshot));
  assign tog_off    = !all_off && rise && (state == ST_ON) && is_toggle;

  always_ff @(posedge clock_1Hz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_OFF;
      cnt      <= '0;
      btn_prev <= 1'b0;
      armed    <= 1'b0;
    end else begin
      btn_prev <= btn;
      armed    <= armed | ~btn;
      if (all_off || tog_off) begin
        state <= ST_OFF;
        cnt   <= '0;
      end else if (load) begin
        state <= ST_ON;
        cnt   <= ON_LOAD;
      end else if (state == ST_ON) begin
        if (cnt == CNT_ONE) begin
          state <= ST_OFF;
          cnt   <= '0;
        end else begin
          cnt <= cnt - CNT_ONE;
        end
      end
    end
  end

  // cnt counts the remaining on-cycles including the current one.
  assign light = (state == ST_ON);
  assign warn  = (WARN_CYCLES != 0) && light && (cnt <= WARN_LIM);

  a_fall_cause: assert property (@(posedge clock_1Hz) disable iff (!reset_n)
    $fell(light) |-> ($past(load, ON_CYCLES + 1) || $past(all_off) || $past(tog_off)));

  a_warn_light: assert property (@(posedge clock_1Hz) disable iff (!reset_n)
    warn |-> light);

endmodule

// File: rtl/timer_switch_multi.sv
// N_CH independent timed light channels plus a registered any-channel-on flag.
// light/warn change at the button edge, any_on one cycle later; no backpressure.
module timer_switch_multi
  import timer_switch_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int ON_CYCLES   = 20,
  parameter int WARN_CYCLES = 3
) (
  input  logic              clock_1Hz,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   btn,
  input  logic [2*N_CH-1:0] mode,
  input  logic              all_off,
  output logic [N_CH-1:0]   light,
  output logic [N_CH-1:0]   warn,
  output logic              any_on
);

  localparam int CW = $clog2(ON_CYCLES + 1);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
    $error("timer_switch_multi: N_CH=%0d outside 1..16", N_CH);
  end
  if (ON_CYCLES < 2 || ON_CYCLES > 65535) begin : g_bad_on
    $error("timer_switch_multi: ON_CYCLES=%0d outside 2..65535", ON_CYCLES);
  end
  if (WARN_CYCLES < 0 || WARN_CYCLES > ON_CYCLES - 1) begin : g_bad_warn
    $error("timer_switch_multi: WARN_CYCLES=%0d outside 0..ON_CYCLES-1", WARN_CYCLES);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_switch_ch #(
      .ON_CYCLES   (ON_CYCLES),
      .WARN_CYCLES (WARN_CYCLES),
      .CW          (CW)
    ) u_ch (
      .clock_1Hz (clock_1Hz),
      .reset_n   (reset_n),
      .btn       (btn[i]),
      .mode      (mode[2*i +: 2]),
      .all_off   (all_off),
      .light     (light[i]),
      .warn      (warn[i])
    );
  end

  always_ff @(posedge clock_1Hz or negedge reset_n) begin
    if (!reset_n) begin
      any_on <= 1'b0;
    end else begin
      any_on <= |light;
    end
  end

endmodule
